// File: rtl/evm_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// the divide-by-zero quotient pattern and a width helper.
package evm_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // All-ones quotient reported for a zero divisor; sliced to WIDTH by users.
  localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, restore on borrow.
module div_step
  #(parameter int WIDTH = 7)
  (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
  );

  // The held partial remainder is always below the divisor, so its top bit is
  // zero and {p, q_msb} equals the shifted P zero-extended to WIDTH+2 bits.
  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  assign p_shift = {p, q[WIDTH-1]};
  assign trial   = p_shift - {2'b00, divisor};
  assign borrow  = trial[WIDTH+1];

  assign p_next = borrow ? p_shift[WIDTH:0] : trial[WIDTH:0];
  assign q_next = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module seq_divider
  import evm_div_pkg::*;
  #(parameter int WIDTH = 7)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
  );

  localparam int CNT_W = clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   p_reg;
  logic [CNT_W-1:0] cnt;
  logic             dbz_reg;

  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p       (p_reg),
    .q       (q_reg),
    .divisor (d_reg),
    .p_next  (p_next),
    .q_next  (q_next)
  );

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      p_reg       <= '0;
      cnt         <= '0;
      dbz_reg     <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            d_reg    <= divisor;
            in_ready <= 1'b0;
            if (divisor != '0) begin
              q_reg   <= dividend;
              p_reg   <= '0;
              cnt     <= CNT_W'(WIDTH);
              dbz_reg <= 1'b0;
              busy    <= 1'b1;
              state   <= S_BUSY;
            end else begin
              // Result is staged here and published one cycle later in DONE.
              q_reg   <= DBZ_QUOTIENT[WIDTH-1:0];
              p_reg   <= {1'b0, dividend};
              dbz_reg <= 1'b1;
              state   <= S_DONE;
            end
          end
        end

        S_BUSY: begin
          q_reg <= q_next;
          p_reg <= p_next;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= p_next[WIDTH-1:0];
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= q_reg;
            remainder   <= p_reg[WIDTH-1:0];
            div_by_zero <= dbz_reg;
          end else if (out_ready) begin
            // quotient/remainder intentionally keep their last values.
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle, parametrised unsigned restoring divider with a valid/ready handshake on both sides.
- Returns quotient and remainder and flags divide-by-zero.
- Computes one quotient bit per clock, replacing a fully unrolled combinational divider.
- Sits between the vote-count registers and the result/percentage display path; accepts one division at a time.

Parameters:
- WIDTH, 7, bit width of dividend, divisor, quotient and remainder (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on dividend/divisor are valid.
- in_ready  output  1  divider can accept new operands.
- dividend  input  WIDTH  unsigned numerator.
- divisor  input  WIDTH  unsigned denominator.
- out_valid  output  1  quotient/remainder/div_by_zero are valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder, always < divisor when divisor != 0.
- div_by_zero  output  1  set with the result when divisor was 0.
- busy  output  1  high in BUSY state.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE; quotient, remainder, div_by_zero, out_valid, busy = 0; in_ready = 1 once reset is released. Internal operand, partial-remainder and counter registers = 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch dividend into the working quotient register and divisor into the divisor register; clear the partial remainder P (WIDTH+1 bits).
  - If divisor!=0: load counter=WIDTH and go to BUSY.
  - If divisor==0: load quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1, and go straight to DONE.
- BUSY (one step per cycle):
  - P = {P[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left by 1.
  - T = P - {1'b0,divisor}, computed in WIDTH+2 bits.
  - If T is negative (MSB of T = 1): Q[0]=0 and P is unchanged. Else Q[0]=1 and P=T.
  - The sign test uses the true borrow bit, never an in-range bit.
  - Decrement the counter; when it reaches 0 after this step, go to DONE.
- DONE:
  - out_valid=1; quotient=Q, remainder=P[WIDTH-1:0].
  - Outputs are held stable while out_ready=0.
  - On out_ready=1, clear out_valid and div_by_zero and go to IDLE.
  - quotient and remainder keep their last values; they are not cleared.
- Latency:
  - divisor!=0: operands accepted at edge k gives out_valid high after edge k+WIDTH.
  - divisor==0: out_valid high after edge k+1.
- Throughput: in_ready is low in BUSY and DONE, so there are no back-to-back accepts. The next accept is possible one cycle after the out_valid&&out_ready handshake.
- Stability: dividend/divisor changes while not in IDLE are ignored. in_valid held high in DONE does not start a new operation.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset mid-operation (BUSY or DONE): abort immediately; all outputs go to their reset values; no partial result is ever presented.
- Edge cases:
  - dividend=0 gives quotient=0, remainder=0.
  - dividend<divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - Max operands ({WIDTH{1}} / {WIDTH{1}}) give quotient=1, remainder=0.

Decomposition:
- Shared package evm_div_pkg holds:
  - the FSM state encoding localparams S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2;
  - the divide-by-zero quotient constant;
  - a clog2 function for CNT_W.
- One natural sub-module, div_step: a combinational single restoring step with inputs P, Q and divisor and outputs next P and next Q. It is parametrised by WIDTH and instantiated once, inside the BUSY datapath.

Test Plan:
- WIDTH=7, 100/7 -> after exactly 7 cycles: out_valid=1, quotient=14, remainder=2, div_by_zero=0; in_ready=0 throughout.
- 45/0 -> out_valid one cycle after accept; quotient=127, remainder=45, div_by_zero=1.
- Boundaries: 127/1 -> 127 r0; 5/9 -> 0 r5; 0/5 -> 0 r0; 127/127 -> 1 r0.
- Backpressure: 100/7 with out_ready low for 5 cycles after out_valid -> quotient/remainder held at 14/2; in_ready stays 0; new in_valid pulses ignored; after out_ready=1, in_ready=1 on the next cycle.
- Reset: assert rst_n=0 three cycles into 100/7 -> outputs 0 immediately (asynchronous). After release, run 50/6 -> 8 r2 with correct 7-cycle latency.
- Random: 1000 random operand pairs at WIDTH=7 and WIDTH=16 with random out_ready -> results match the reference model's / and %; latency is exact.
